// File: rtl/recv_program_fsm_pkg.sv
// Shared constants for the UART program loader: default widths, halt word and state encodings.
package recv_program_fsm_pkg;

    localparam int unsigned DEF_UART_BITS        = 8;
    localparam int unsigned DEF_INSTRUCTION_BITS = 32;
    localparam int unsigned DEF_INST_ADDRS_BITS  = 10;
    localparam logic [31:0] DEF_HALT_WORD        = 32'hFFFF_FFFF;

    localparam int unsigned STATE_BITS = 3;
    typedef logic [STATE_BITS-1:0] state_t;

    localparam logic [2:0] ST_IDLE          = 3'd0;
    localparam logic [2:0] ST_WAIT_BYTE     = 3'd1;
    localparam logic [2:0] ST_WRITE_INST    = 3'd2;
    localparam logic [2:0] ST_WAIT_CHECKSUM = 3'd3;
    localparam logic [2:0] ST_FINISH        = 3'd4;

endpackage

// File: rtl/recv_program_fsm.sv
// Assembles UART bytes (MSB first) into instruction words and writes them to instruction memory.
// Optional trailing checksum byte enabled by defining RECV_CHECKSUM_EN.
module recv_program_fsm
    import recv_program_fsm_pkg::*;
#(
    parameter int unsigned UART_BITS        = DEF_UART_BITS,
    parameter int unsigned INSTRUCTION_BITS = DEF_INSTRUCTION_BITS,
    parameter int unsigned INST_ADDRS_BITS  = DEF_INST_ADDRS_BITS,
    parameter logic [INSTRUCTION_BITS-1:0] HALT_WORD = INSTRUCTION_BITS'(DEF_HALT_WORD)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_start,
    input  logic                        i_rx_done,
    input  logic [UART_BITS-1:0]        i_rx_data,
    output logic                        o_inst_wr_en,
    output logic [INST_ADDRS_BITS-1:0]  o_inst_wr_addr,
    output logic [INSTRUCTION_BITS-1:0] o_inst_wr_data,
    output logic                        o_busy,
    output logic                        o_done,
    output logic                        o_error
);

    localparam int unsigned BYTES_PER_WORD = INSTRUCTION_BITS / UART_BITS;
    localparam int unsigned CNT_BITS = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
    localparam logic [CNT_BITS-1:0] LAST_BYTE = CNT_BITS'(BYTES_PER_WORD - 1);
    localparam logic [INST_ADDRS_BITS-1:0] ADDR_MAX = '1;

    state_t                        state, state_nxt;
    logic [INST_ADDRS_BITS-1:0]    addr, addr_nxt;
    logic [CNT_BITS-1:0]           cnt, cnt_nxt;
    logic [INSTRUCTION_BITS-1:0]   word, word_nxt;
    logic                          error_nxt;
    logic                          wr_en_nxt;
    logic [INST_ADDRS_BITS-1:0]    wr_addr_nxt;
    logic [INSTRUCTION_BITS-1:0]   wr_data_nxt;
    logic                          busy_nxt;
    logic                          done_nxt;
`ifdef RECV_CHECKSUM_EN
    logic [7:0]                    acc, acc_nxt;
`endif

    // State and registered outputs; synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state          <= ST_IDLE;
            addr           <= '0;
            cnt            <= '0;
            word           <= '0;
            o_error        <= 1'b0;
            o_inst_wr_en   <= 1'b0;
            o_inst_wr_addr <= '0;
            o_inst_wr_data <= '0;
            o_busy         <= 1'b0;
            o_done         <= 1'b0;
`ifdef RECV_CHECKSUM_EN
            acc            <= '0;
`endif
        end else begin
            state          <= state_nxt;
            addr           <= addr_nxt;
            cnt            <= cnt_nxt;
            word           <= word_nxt;
            o_error        <= error_nxt;
            o_inst_wr_en   <= wr_en_nxt;
            o_inst_wr_addr <= wr_addr_nxt;
            o_inst_wr_data <= wr_data_nxt;
            o_busy         <= busy_nxt;
            o_done         <= done_nxt;
`ifdef RECV_CHECKSUM_EN
            acc            <= acc_nxt;
`endif
        end
    end

    // Next-state, datapath and output decode
    always_comb begin
        state_nxt = state;
        addr_nxt  = addr;
        cnt_nxt   = cnt;
        word_nxt  = word;
        error_nxt = o_error;
`ifdef RECV_CHECKSUM_EN
        acc_nxt   = acc;
`endif

        case (state)
            ST_IDLE: begin
                if (i_start) begin
                    addr_nxt  = '0;
                    cnt_nxt   = '0;
                    word_nxt  = '0;
                    error_nxt = 1'b0;
`ifdef RECV_CHECKSUM_EN
                    acc_nxt   = '0;
`endif
                    state_nxt = ST_WAIT_BYTE;
                end
            end
            ST_WAIT_BYTE: begin
                if (i_rx_done) begin
                    word_nxt = {word[INSTRUCTION_BITS-UART_BITS-1:0], i_rx_data};
`ifdef RECV_CHECKSUM_EN
                    acc_nxt  = acc ^ 8'(i_rx_data);
`endif
                    if (cnt == LAST_BYTE) begin
                        cnt_nxt   = '0;
                        state_nxt = ST_WRITE_INST;
                    end else begin
                        cnt_nxt = cnt + CNT_BITS'(1);
                    end
                end
            end
            ST_WRITE_INST: begin
                addr_nxt = addr + INST_ADDRS_BITS'(1);
                // A byte arriving while the word is being written cannot be captured
                if (i_rx_done) error_nxt = 1'b1;
                if (word == HALT_WORD) begin
`ifdef RECV_CHECKSUM_EN
                    state_nxt = ST_WAIT_CHECKSUM;
`else
                    state_nxt = ST_FINISH;
`endif
                end else if (addr == ADDR_MAX) begin
                    error_nxt = 1'b1;
                    state_nxt = ST_FINISH;
                end else begin
                    state_nxt = ST_WAIT_BYTE;
                end
            end
`ifdef RECV_CHECKSUM_EN
            ST_WAIT_CHECKSUM: begin
                if (i_rx_done) begin
                    if (8'(i_rx_data) != acc) error_nxt = 1'b1;
                    state_nxt = ST_FINISH;
                end
            end
`endif
            ST_FINISH: begin
                if (i_rx_done) error_nxt = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase

        // Outputs are registered from the upcoming state so they align with it
        wr_en_nxt   = (state_nxt == ST_WRITE_INST);
        wr_addr_nxt = wr_en_nxt ? addr_nxt : '0;
        wr_data_nxt = wr_en_nxt ? word_nxt : '0;
        busy_nxt    = (state_nxt != ST_IDLE);
        done_nxt    = (state_nxt == ST_FINISH);
    end

endmodule

// File: doc/recv_program_fsm.md
RECV_PROGRAM_FSM -- requirements
Module: recv_program_fsm

Interface
REQ-001 SHALL have parameters: UART_BITS, default 8, UART byte width; INSTRUCTION_BITS, default 32, instruction word width; INST_ADDRS_BITS, default 10, instruction memory address width; HALT_WORD, default 32'hFFFF_FFFF, program terminator.
REQ-002 SHALL have ports, in this order:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-low
- i_start  input  1  begin a program load
- i_rx_done  input  1  one-cycle pulse; i_rx_data valid
- i_rx_data  input  UART_BITS  received byte
- o_inst_wr_en  output  1  instruction memory write strobe
- o_inst_wr_addr  output  INST_ADDRS_BITS  write address
- o_inst_wr_data  output  INSTRUCTION_BITS  write data
- o_busy  output  1  load in progress
- o_done  output  1  one-cycle pulse at load end
- o_error  output  1  sticky load error

Function
REQ-003 SHALL implement states IDLE, WAIT_BYTE, WRITE_INST, WAIT_CHECKSUM (macro only) and FINISH.
REQ-004 IDLE: on i_start, SHALL clear the address, byte count, word register, XOR accumulator and o_error, then enter WAIT_BYTE; other inputs are ignored.
REQ-005 WAIT_BYTE: on i_rx_done, SHALL update the word register to {word[INSTRUCTION_BITS-UART_BITS-1:0], i_rx_data}, MSB first.
REQ-006 The byte count SHALL increment on each captured byte; on the 4th byte it SHALL reset to 0 and the next state SHALL be WRITE_INST.
REQ-007 WRITE_INST SHALL last exactly one cycle, asserting o_inst_wr_en=1 with o_inst_wr_addr=current address and o_inst_wr_data=assembled word; write latency is 1 cycle after the 4th i_rx_done.
REQ-008 On leaving WRITE_INST, the address SHALL increment modulo 2^INST_ADDRS_BITS.
REQ-009 From WRITE_INST, if word==HALT_WORD the next state SHALL be FINISH (or WAIT_CHECKSUM with the macro); the halt word itself SHALL be written.
REQ-010 From WRITE_INST, if word!=HALT_WORD and the address equals its maximum (all ones), the next state SHALL be FINISH with o_error set (overflow, wrap-around).
REQ-011 From WRITE_INST, in all other cases the next state SHALL be WAIT_BYTE.
REQ-012 An i_rx_done in WRITE_INST or FINISH SHALL NOT be captured and SHALL set o_error (overrun).
REQ-013 FINISH SHALL assert o_done=1 for one cycle, then enter IDLE.
REQ-014 o_error SHALL hold until the next accepted i_start.
REQ-015 o_busy SHALL be 1 in every state except IDLE.
REQ-016 i_start outside IDLE SHALL be ignored.
REQ-017 Outside WRITE_INST, o_inst_wr_en SHALL be 0, and o_inst_wr_addr and o_inst_wr_data SHALL be 0.

Reset
REQ-018 With rst=0 at a clk edge, SHALL enter IDLE with every output 0 and all internal registers 0, including mid-load; a write strobe SHALL NOT appear in the cycle after reset.

Configuration
REQ-019 With RECV_CHECKSUM_EN defined, SHALL XOR every captured program byte, including the halt word bytes, into an 8-bit accumulator.
REQ-020 With RECV_CHECKSUM_EN defined, after the halt write SHALL enter WAIT_CHECKSUM; on i_rx_done, if the byte != accumulator it SHALL set o_error; either way it SHALL enter FINISH.
REQ-021 Without RECV_CHECKSUM_EN, SHALL contain no accumulator and no WAIT_CHECKSUM, and the halt write SHALL go directly to FINISH.

Structure
REQ-022 The shared constants header SHALL provide the state encodings, HALT_WORD, and the UART_BITS, INSTRUCTION_BITS and INST_ADDRS_BITS defaults.
REQ-023 The state register SHALL be 3 bits.
REQ-024 SHALL have no sub-module; the byte-to-word assembler stays inline.

Verification
REQ-025 Bytes 20 01 00 05, FF FF FF FF -> writes (0, 32'h20010005) and (1, 32'hFFFFFFFF), o_done pulse, o_error=0.
REQ-026 Reset asserted after 2 of 4 bytes -> all outputs 0; a following i_start plus 4 bytes -> write at address 0 containing only the new bytes.
REQ-027 INST_ADDRS_BITS=2 with 4 non-halt words -> writes at 0..3, then FINISH with o_error=1 and no write at address 0.
REQ-028 i_rx_done pulse in the WRITE_INST cycle -> byte dropped, o_error=1, load continues to o_done.
REQ-029 RECV_CHECKSUM_EN with program 00 00 00 01 + halt, checksum byte 01 -> o_error=0; checksum byte 00 -> o_error=1, o_done still pulses.
REQ-030 i_start pulsed while o_busy=1 -> no state, address or word change.
